// File: rtl/sound_event_scheduler.sv
// Priority scheduler sharing one tone generator among sound events; pending on the req edge, tone on the next edge.
// Never backpressures requesters: pulses latch into pending bits, repeats collapse, and a preempted jingle is dropped.
module sound_event_scheduler #(
  parameter int NUM_EVENTS  = 5,
  parameter int NOTE_FRAMES = 4,
  parameter int GAP_FRAMES  = 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic [NUM_EVENTS-1:0] req,
  input  logic                  mute,
  output logic [9:0]            freq,
  output logic                  sound_en,
  output logic                  busy,
  output logic [2:0]            cur_event
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int MAX_FRAMES = (NOTE_FRAMES > GAP_FRAMES) ? NOTE_FRAMES : GAP_FRAMES;
  localparam int FCW        = $clog2(MAX_FRAMES) + 1;
  localparam logic [FCW-1:0] NOTE_LAST = FCW'(NOTE_FRAMES - 1);
  localparam logic [FCW-1:0] GAP_LAST  = FCW'(GAP_FRAMES - 1);

  logic [1:0]            state;
  logic [NUM_EVENTS-1:0] pending;
  logic [NUM_EVENTS-1:0] clr_mask;
  logic                  note;
  logic [FCW-1:0]        frame_cnt;
  logic                  sel_vld;
  logic [2:0]            sel_idx;
  logic                  preempt;
  logic                  launch;

  function automatic logic [9:0] note_freq(input logic [2:0] ev, input logic n);
    case (ev)
      3'd0:    return n ? 10'd659 : 10'd523;
      3'd1:    return n ? 10'd131 : 10'd196;
      3'd2:    return n ? 10'd880 : 10'd440;
      3'd3:    return n ? 10'd262 : 10'd330;
      3'd4:    return n ? 10'd698 : 10'd784;
      default: return 10'd0;
    endcase
  endfunction

  // Lowest set index wins; scanning downward leaves the smallest index last.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 3'd0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_vld = 1'b1;
        sel_idx = 3'(i);
      end
    end
  end

  assign preempt = (state == S_PLAY) && sel_vld && (sel_idx < cur_event);
  assign launch  = ((state == S_IDLE) && sel_vld) || preempt;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      clr_mask[i] = launch && (sel_idx == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= S_IDLE;
      pending   <= '0;
      freq      <= 10'd0;
      sound_en  <= 1'b0;
      busy      <= 1'b0;
      cur_event <= 3'd0;
      note      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      // A request on the same edge as its own launch re-arms the bit.
      pending <= (pending & ~clr_mask) | req;
      if (launch) begin
        cur_event <= sel_idx;
        note      <= 1'b0;
        frame_cnt <= '0;
        freq      <= note_freq(sel_idx, 1'b0);
        sound_en  <= !mute;
        state     <= S_PLAY;
        busy      <= 1'b1;
      end else begin
        case (state)
          S_PLAY: begin
            sound_en <= !mute;
            if (startOfFrame) begin
              if (frame_cnt == NOTE_LAST) begin
                frame_cnt <= '0;
                if (!note) begin
                  note <= 1'b1;
                  freq <= note_freq(cur_event, 1'b1);
                end else begin
                  sound_en <= 1'b0;
                  freq     <= 10'd0;
                  state    <= S_GAP;
                end
              end else begin
                frame_cnt <= frame_cnt + FCW'(1);
              end
            end
          end
          S_GAP: begin
            sound_en <= 1'b0;
            if (startOfFrame) begin
              if (frame_cnt == GAP_LAST) begin
                frame_cnt <= '0;
                state     <= S_IDLE;
                busy      <= 1'b0;
              end else begin
                frame_cnt <= frame_cnt + FCW'(1);
              end
            end
          end
          default: begin
            sound_en <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for sound_event_scheduler: jingle timing, priority, preemption, mute and async reset.
module tb_sound_event_scheduler;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic [4:0] req;
  logic       mute;
  logic [9:0] freq;
  logic       sound_en;
  logic       busy;
  logic [2:0] cur_event;

  int total;
  int passed;

  sound_event_scheduler #(.NUM_EVENTS(5), .NOTE_FRAMES(4), .GAP_FRAMES(1)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .req(req), .mute(mute),
    .freq(freq), .sound_en(sound_en), .busy(busy), .cur_event(cur_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [4:0] v);
    req = v;
    step();
    req = 5'd0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    step();
    step();
    resetN = 1'b1;
    step();
    total++; if (freq !== 10'd0) $display("FAIL rst_freq got %0d want 0", freq); else passed++;
    total++; if (sound_en !== 1'b0) $display("FAIL rst_sound_en got %0b want 0", sound_en); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else passed++;
    total++; if (cur_event !== 3'd0) $display("FAIL rst_cur_event got %0d want 0", cur_event); else passed++;
  endtask

  task automatic test_shot();
    pulse_req(5'b10000);
    total++; if (sound_en !== 1'b0) $display("FAIL shot_pending_only sound_en got %0b want 0", sound_en); else passed++;
    step();
    total++; if (sound_en !== 1'b1) $display("FAIL shot_start sound_en got %0b want 1", sound_en); else passed++;
    total++; if (freq !== 10'd784) $display("FAIL shot_note0 freq got %0d want 784", freq); else passed++;
    total++; if (cur_event !== 3'd4) $display("FAIL shot_cur got %0d want 4", cur_event); else passed++;
    frames(3);
    total++; if (freq !== 10'd784) $display("FAIL shot_3frames freq got %0d want 784", freq); else passed++;
    frames(1);
    total++; if (freq !== 10'd698) $display("FAIL shot_note1 freq got %0d want 698", freq); else passed++;
    frames(4);
    total++; if (sound_en !== 1'b0) $display("FAIL shot_gap sound_en got %0b want 0", sound_en); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL shot_gap busy got %0b want 1", busy); else passed++;
    total++; if (freq !== 10'd0) $display("FAIL shot_gap freq got %0d want 0", freq); else passed++;
    frames(1);
    total++; if (busy !== 1'b0) $display("FAIL shot_done busy got %0b want 0", busy); else passed++;
  endtask

  task automatic test_priority();
    pulse_req(5'b01010);
    step();
    total++; if (cur_event !== 3'd1) $display("FAIL prio_first cur got %0d want 1", cur_event); else passed++;
    total++; if (freq !== 10'd196) $display("FAIL prio_ev1_n0 freq got %0d want 196", freq); else passed++;
    frames(4);
    total++; if (freq !== 10'd131) $display("FAIL prio_ev1_n1 freq got %0d want 131", freq); else passed++;
    frames(4);
    total++; if (busy !== 1'b1 || sound_en !== 1'b0) $display("FAIL prio_gap busy/en got %0b/%0b want 1/0", busy, sound_en); else passed++;
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL prio_idle busy got %0b want 0", busy); else passed++;
    step();
    total++; if (cur_event !== 3'd3) $display("FAIL prio_second cur got %0d want 3", cur_event); else passed++;
    total++; if (freq !== 10'd330) $display("FAIL prio_ev3_n0 freq got %0d want 330", freq); else passed++;
    frames(4);
    total++; if (freq !== 10'd262) $display("FAIL prio_ev3_n1 freq got %0d want 262", freq); else passed++;
    frames(5);
    repeat (4) step();
    total++; if (busy !== 1'b0) $display("FAIL prio_drained busy got %0b want 0", busy); else passed++;
  endtask

  task automatic test_preempt();
    pulse_req(5'b10000);
    step();
    frames(2);
    pulse_req(5'b00001);
    total++; if (freq !== 10'd784) $display("FAIL pre_before freq got %0d want 784", freq); else passed++;
    step();
    total++; if (freq !== 10'd523) $display("FAIL pre_launch freq got %0d want 523", freq); else passed++;
    total++; if (cur_event !== 3'd0) $display("FAIL pre_launch cur got %0d want 0", cur_event); else passed++;
    frames(3);
    total++; if (freq !== 10'd523) $display("FAIL pre_3frames freq got %0d want 523", freq); else passed++;
    frames(1);
    total++; if (freq !== 10'd659) $display("FAIL pre_note1 freq got %0d want 659", freq); else passed++;
    frames(5);
    repeat (5) step();
    total++; if (busy !== 1'b0) $display("FAIL pre_no_resume busy got %0b want 0", busy); else passed++;
    total++; if (cur_event !== 3'd0) $display("FAIL pre_last cur got %0d want 0", cur_event); else passed++;
  endtask

  task automatic test_no_preempt();
    pulse_req(5'b00001);
    step();
    frames(1);
    pulse_req(5'b00100);
    step();
    total++; if (cur_event !== 3'd0 || freq !== 10'd523) $display("FAIL nopre_hold cur/freq got %0d/%0d want 0/523", cur_event, freq); else passed++;
    frames(3);
    total++; if (freq !== 10'd659) $display("FAIL nopre_note1 freq got %0d want 659", freq); else passed++;
    frames(4);
    total++; if (cur_event !== 3'd0 || busy !== 1'b1) $display("FAIL nopre_gap cur/busy got %0d/%0b want 0/1", cur_event, busy); else passed++;
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL nopre_idle busy got %0b want 0", busy); else passed++;
    step();
    total++; if (cur_event !== 3'd2 || freq !== 10'd440) $display("FAIL nopre_ev2 cur/freq got %0d/%0d want 2/440", cur_event, freq); else passed++;
    frames(9);
  endtask

  task automatic test_mute();
    mute = 1'b1;
    pulse_req(5'b00100);
    step();
    total++; if (busy !== 1'b1 || sound_en !== 1'b0) $display("FAIL mute_start busy/en got %0b/%0b want 1/0", busy, sound_en); else passed++;
    total++; if (freq !== 10'd440) $display("FAIL mute_note0 freq got %0d want 440", freq); else passed++;
    frames(4);
    total++; if (freq !== 10'd880 || sound_en !== 1'b0) $display("FAIL mute_note1 freq/en got %0d/%0b want 880/0", freq, sound_en); else passed++;
    frames(4);
    total++; if (busy !== 1'b1 || freq !== 10'd0) $display("FAIL mute_gap busy/freq got %0b/%0d want 1/0", busy, freq); else passed++;
    frames(1);
    total++; if (busy !== 1'b0) $display("FAIL mute_done busy got %0b want 0", busy); else passed++;
    mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_req(5'b00001);
    step();
    frames(1);
    pulse_req(5'b00010);
    total++; if (cur_event !== 3'd0 || sound_en !== 1'b1) $display("FAIL rmid_playing cur/en got %0d/%0b want 0/1", cur_event, sound_en); else passed++;
    #2;
    resetN = 1'b0;
    #1;
    total++; if (sound_en !== 1'b0 || freq !== 10'd0) $display("FAIL rmid_async en/freq got %0b/%0d want 0/0", sound_en, freq); else passed++;
    total++; if (busy !== 1'b0 || cur_event !== 3'd0) $display("FAIL rmid_async busy/cur got %0b/%0d want 0/0", busy, cur_event); else passed++;
    step();
    step();
    resetN = 1'b1;
    repeat (3) step();
    frames(2);
    total++; if (busy !== 1'b0 || sound_en !== 1'b0 || freq !== 10'd0) $display("FAIL rmid_after busy/en/freq got %0b/%0b/%0d want 0/0/0", busy, sound_en, freq); else passed++;
  endtask

  initial begin
    total        = 0;
    passed       = 0;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    req          = 5'd0;
    mute         = 1'b0;
    test_reset();
    test_shot();
    test_priority();
    test_preempt();
    test_no_preempt();
    test_mute();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
